// File: rtl/cgmii_word_builder_if.sv
// Bus between the frame-generator side and the CGMII word builder.
// Ports (slave = word builder):
//   i_enable       clock enable into the builder
//   i_fsm_state    one-hot frame-generator state
//   o_tx_data      registered CGMII data word (lane 0 = bits [7:0])
//   o_tx_ctrl      registered CGMII control word (bit k qualifies lane k)
//   o_frame_count  terminate words emitted (wrapping)
//   o_error_count  error words emitted (saturating)
interface cgmii_word_builder_if #(
   parameter int unsigned DATA_NBIT = 64,
   parameter int unsigned CTRL_NBIT = 8,
   parameter int unsigned N_STATES  = 5,
   parameter int unsigned CNT_NBIT  = 16
);
   logic                 i_enable;
   logic [N_STATES-1:0]  i_fsm_state;
   logic [DATA_NBIT-1:0] o_tx_data;
   logic [CTRL_NBIT-1:0] o_tx_ctrl;
   logic [CNT_NBIT-1:0]  o_frame_count;
   logic [CNT_NBIT-1:0]  o_error_count;

   modport master (
      output i_enable, i_fsm_state,
      input  o_tx_data, o_tx_ctrl, o_frame_count, o_error_count
   );

   modport slave (
      input  i_enable, i_fsm_state,
      output o_tx_data, o_tx_ctrl, o_frame_count, o_error_count
   );
endinterface

// File: rtl/cgmii_word_builder.sv
// Turns the frame-generator one-hot state into one registered CGMII
// data/control word per cycle and keeps frame/error statistics.
// Ports:
//   i_clock  system clock (rising edge)
//   i_reset  asynchronous active-low reset
//   bus      cgmii_word_builder_if slave: enable, state in; word, counters out
module cgmii_word_builder #(
   parameter int unsigned DATA_NBIT = 64,
   parameter int unsigned CTRL_NBIT = 8,
   parameter int unsigned N_STATES  = 5,
   parameter int unsigned CNT_NBIT  = 16
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   cgmii_word_builder_if.slave    bus
);

   localparam int unsigned LANE_NBIT = 8;

   localparam logic [N_STATES-1:0] ST_INIT = N_STATES'(5'b00001);
   localparam logic [N_STATES-1:0] ST_TX_C = N_STATES'(5'b00010);
   localparam logic [N_STATES-1:0] ST_TX_D = N_STATES'(5'b00100);
   localparam logic [N_STATES-1:0] ST_TX_T = N_STATES'(5'b01000);

   localparam logic [DATA_NBIT-1:0] IDLE_DATA  = DATA_NBIT'({CTRL_NBIT{8'h07}});
   localparam logic [DATA_NBIT-1:0] START_DATA =
      DATA_NBIT'({8'hD5, {(CTRL_NBIT-2){8'h55}}, 8'hFB});
   localparam logic [DATA_NBIT-1:0] TERM_DATA  =
      DATA_NBIT'({{(CTRL_NBIT-1){8'h07}}, 8'hFD});
   localparam logic [DATA_NBIT-1:0] ERR_DATA   = DATA_NBIT'({CTRL_NBIT{8'hFE}});

   logic [DATA_NBIT-1:0] data_q,  data_d;
   logic [CTRL_NBIT-1:0] ctrl_q,  ctrl_d;
   logic [CNT_NBIT-1:0]  frame_q, frame_d;
   logic [CNT_NBIT-1:0]  err_q,   err_d;
   logic [N_STATES-1:0]  prev_q,  prev_d;
   logic [LANE_NBIT-1:0] seed_q,  seed_d;

   // Word selection and statistics update for the sampled state.
   always_comb begin
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      frame_d = frame_q;
      err_d   = err_q;
      prev_d  = prev_q;
      seed_d  = seed_q;
      if (bus.i_enable) begin
         // Invalid codes are kept as-is so a following TX_D restarts the frame.
         prev_d = bus.i_fsm_state;
         case (bus.i_fsm_state)
            ST_INIT, ST_TX_C: begin
               data_d = IDLE_DATA;
               ctrl_d = '1;
            end
            ST_TX_D: begin
               if (prev_q != ST_TX_D) begin
                  data_d = START_DATA;
                  ctrl_d = CTRL_NBIT'(1);
                  seed_d = '0;
               end else begin
                  for (int k = 0; k < int'(CTRL_NBIT); k++) begin
                     data_d[k*LANE_NBIT +: LANE_NBIT] = seed_q + LANE_NBIT'(k);
                  end
                  ctrl_d = '0;
                  seed_d = seed_q + LANE_NBIT'(CTRL_NBIT);
               end
            end
            ST_TX_T: begin
               data_d  = TERM_DATA;
               ctrl_d  = '1;
               frame_d = frame_q + CNT_NBIT'(1);
            end
            default: begin
               // TX_E and every non-one-hot code.
               data_d = ERR_DATA;
               ctrl_d = '1;
               if (err_q != '1) begin
                  err_d = err_q + CNT_NBIT'(1);
               end
            end
         endcase
      end
   end

   // State registers; reset drops straight to the idle word.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         data_q  <= IDLE_DATA;
         ctrl_q  <= '1;
         frame_q <= '0;
         err_q   <= '0;
         prev_q  <= ST_INIT;
         seed_q  <= '0;
      end else begin
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         frame_q <= frame_d;
         err_q   <= err_d;
         prev_q  <= prev_d;
         seed_q  <= seed_d;
      end
   end

   assign bus.o_tx_data     = data_q;
   assign bus.o_tx_ctrl     = ctrl_q;
   assign bus.o_frame_count = frame_q;
   assign bus.o_error_count = err_q;

endmodule

// File: tb/tb_cgmii_word_builder.sv
// Self-checking bench for cgmii_word_builder: vector table plus
// hand-written sequences for reset, wrap and saturation corners.
module tb_cgmii_word_builder;

   localparam logic [4:0] INIT = 5'b00001;
   localparam logic [4:0] TXC  = 5'b00010;
   localparam logic [4:0] TXD  = 5'b00100;
   localparam logic [4:0] TXT  = 5'b01000;
   localparam logic [4:0] TXE  = 5'b10000;

   localparam logic [63:0] IDLE  = 64'h0707070707070707;
   localparam logic [63:0] START = 64'hD5555555555555FB;
   localparam logic [63:0] TERM  = 64'h07070707070707FD;
   localparam logic [63:0] ERRW  = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [63:0] P0    = 64'h0706050403020100;
   localparam logic [63:0] P8    = 64'h0F0E0D0C0B0A0908;
   localparam logic [63:0] P16   = 64'h1716151413121110;

   typedef struct {
      logic        en;
      logic [4:0]  st;
      logic [63:0] d;
      logic [7:0]  c;
      logic [15:0] fc;
      logic [15:0] ec;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cgmii_word_builder_if bus ();
   cgmii_word_builder_if #(.CNT_NBIT(4)) bus_s ();

   cgmii_word_builder dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus.slave)
   );

   cgmii_word_builder #(.CNT_NBIT(4)) dut_s (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus_s.slave)
   );

   int checks = 0;
   int failures = 0;
   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [63:0] d, input logic [7:0] c,
                          input logic [15:0] fc, input logic [15:0] ec);
      chk({name, ".data"},  bus.o_tx_data, d);
      chk({name, ".ctrl"},  64'(bus.o_tx_ctrl), 64'(c));
      chk({name, ".frame"}, 64'(bus.o_frame_count), 64'(fc));
      chk({name, ".error"}, 64'(bus.o_error_count), 64'(ec));
   endtask

   task automatic cycle(input logic en, input logic [4:0] st);
      @(negedge clk);
      bus.i_enable    = en;
      bus.i_fsm_state = st;
      @(posedge clk);
      #1;
   endtask

   task automatic cycle_s(input logic [4:0] st);
      @(negedge clk);
      bus_s.i_enable    = 1'b1;
      bus_s.i_fsm_state = st;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic en, input logic [4:0] st, input logic [63:0] d,
                               input logic [7:0] c, input logic [15:0] fc, input logic [15:0] ec);
      vec_t v;
      v.en = en; v.st = st; v.d = d; v.c = c; v.fc = fc; v.ec = ec;
      return v;
   endfunction

   // Independent model of a payload word starting at the given seed.
   function automatic logic [63:0] pay(input int seed);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'((seed + k) % 256);
      return r;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.i_enable      = 1'b0;
      bus.i_fsm_state   = INIT;
      bus_s.i_enable    = 1'b0;
      bus_s.i_fsm_state = INIT;

      // reset and idle, normal frame, errors, enable hold, corner states
      vq.push_back(mk(1, INIT, IDLE, 8'hFF, 0, 0));
      for (int i = 0; i < 6; i++) vq.push_back(mk(1, TXC, IDLE, 8'hFF, 0, 0));
      vq.push_back(mk(1, TXD, START, 8'h01, 0, 0));
      vq.push_back(mk(1, TXD, P0, 8'h00, 0, 0));
      vq.push_back(mk(1, TXD, P8, 8'h00, 0, 0));
      vq.push_back(mk(1, TXT, TERM, 8'hFF, 1, 0));
      vq.push_back(mk(1, INIT, IDLE, 8'hFF, 1, 0));
      vq.push_back(mk(1, TXE, ERRW, 8'hFF, 1, 1));
      vq.push_back(mk(1, 5'b00110, ERRW, 8'hFF, 1, 2));
      vq.push_back(mk(1, TXD, START, 8'h01, 1, 2));
      vq.push_back(mk(1, TXD, P0, 8'h00, 1, 2));
      vq.push_back(mk(1, TXD, P8, 8'h00, 1, 2));
      vq.push_back(mk(0, TXE, P8, 8'h00, 1, 2));
      vq.push_back(mk(0, TXT, P8, 8'h00, 1, 2));
      vq.push_back(mk(0, INIT, P8, 8'h00, 1, 2));
      vq.push_back(mk(0, TXD, P8, 8'h00, 1, 2));
      vq.push_back(mk(1, TXD, P16, 8'h00, 1, 2));
      vq.push_back(mk(1, TXT, TERM, 8'hFF, 2, 2));
      vq.push_back(mk(1, 5'b00000, ERRW, 8'hFF, 2, 3));
      vq.push_back(mk(1, TXT, TERM, 8'hFF, 3, 3));
      vq.push_back(mk(1, TXD, START, 8'h01, 3, 3));
      vq.push_back(mk(1, TXD, P0, 8'h00, 3, 3));
      vq.push_back(mk(1, TXT, TERM, 8'hFF, 4, 3));
      vq.push_back(mk(1, TXD, START, 8'h01, 4, 3));
      vq.push_back(mk(1, TXT, TERM, 8'hFF, 5, 3));
      vq.push_back(mk(1, 5'b11111, ERRW, 8'hFF, 5, 4));
      vq.push_back(mk(1, TXD, START, 8'h01, 5, 4));
      vq.push_back(mk(1, INIT, IDLE, 8'hFF, 5, 4));

      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", IDLE, 8'hFF, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         cycle(vq[i].en, vq[i].st);
         chk_all($sformatf("vec%0d", i), vq[i].d, vq[i].c, vq[i].fc, vq[i].ec);
      end

      // asynchronous reset in the middle of a payload
      cycle(1, TXD);
      chk("midrst.start", bus.o_tx_data, START);
      cycle(1, TXD);
      chk("midrst.pay", bus.o_tx_data, P0);
      #2;
      bus.i_fsm_state = INIT;
      rst_n = 1'b0;
      #1;
      chk_all("midrst.async", IDLE, 8'hFF, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 33-cycle frame: start then 32 payloads, seed wraps afterwards
      cycle(1, TXD);
      chk_all("long.start", START, 8'h01, 0, 0);
      for (int j = 1; j <= 32; j++) begin
         cycle(1, TXD);
         chk($sformatf("long.pay%0d", j), bus.o_tx_data, pay(8 * (j - 1)));
      end
      chk("long.last", bus.o_tx_data, 64'hFFFEFDFCFBFAF9F8);
      cycle(1, TXD);
      chk_all("long.wrap", P0, 8'h00, 0, 0);
      cycle(1, TXT);
      chk_all("long.term", TERM, 8'hFF, 1, 0);

      // error counter saturation
      for (int i = 0; i < 16'hFFFE; i++) cycle(1, TXE);
      chk_all("sat.fffe", ERRW, 8'hFF, 1, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         cycle(1, TXE);
         chk_all($sformatf("sat.hold%0d", i), ERRW, 8'hFF, 1, 16'hFFFF);
      end

      // frame counter wrap on the narrow-counter instance
      for (int i = 0; i < 15; i++) cycle_s(TXT);
      chk("wrap.max", 64'(bus_s.o_frame_count), 64'hF);
      cycle_s(TXT);
      chk("wrap.zero", 64'(bus_s.o_frame_count), 64'h0);
      chk("wrap.data", bus_s.o_tx_data, TERM);
      chk("wrap.err", 64'(bus_s.o_error_count), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
